// File: rtl/gaa_fitness_engine.sv
// ============================================================================
// Module   : gaa_fitness_engine
// Purpose  : Fitness evaluator for the genetic-algorithm accelerator. Streams
//            COUNT chromosomes from SDRAM (BASE, BASE+DATA_W/8, ...) over a
//            pipelined Avalon-MM read master with up to MAX_OUT reads in
//            flight. Each word is scored as the number of bits equal to
//            TARGET. Best fitness/index and fitness sum are readable through
//            an Avalon-MM slave.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            hps_*                - Avalon-MM slave (8 registers, 32-bit data,
//                                   combinational read data)
//            sdram_*              - Avalon-MM pipelined read master
// Registers: 0 CTRL (wr bit0 = start, rd {done,busy}), 1 BASE, 2 COUNT,
//            3 TARGET, 4 BEST_FIT, 5 BEST_IDX, 6 SUM_FIT, 7 WORST_FIT
// Options  : GAA_FITNESS_WORST_EN - adds minimum-fitness tracking (addr 7);
//            without it address 7 reads zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gaa_fitness_engine #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 25,
    parameter int POP_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            hps_address,
    input  logic                  hps_chipselect,
    input  logic                  hps_write,
    input  logic                  hps_read,
    input  logic [31:0]           hps_writedata,
    output logic [31:0]           hps_readdata,
    output logic                  hps_waitrequest,
    output logic [ADDR_W-1:0]     sdram_address,
    output logic [DATA_W/8-1:0]   sdram_byteenable_n,
    output logic                  sdram_chipselect,
    output logic                  sdram_read_n,
    input  logic [DATA_W-1:0]     sdram_readdata,
    input  logic                  sdram_readdatavalid,
    input  logic                  sdram_waitrequest
);

    localparam int FIT_W  = $clog2(DATA_W + 1);
    localparam int SUM_W  = FIT_W + POP_W;
    localparam int PEND_W = $clog2(MAX_OUT + 1);

    localparam logic [ADDR_W-1:0] c_WORD_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [PEND_W-1:0] c_MAX_OUT    = PEND_W'(MAX_OUT);
    localparam logic [PEND_W-1:0] c_PEND_ONE   = PEND_W'(1);
    localparam logic [POP_W-1:0]  c_POP_ONE    = POP_W'(1);
    localparam logic [FIT_W-1:0]  c_FIT_MAX    = FIT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_base;
    logic [POP_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_target;
    logic [FIT_W-1:0]    r_best_fit;
    logic [POP_W-1:0]    r_best_idx;
    logic [SUM_W-1:0]    r_sum_fit;
    logic                r_done;
    logic                r_busy;
    logic [POP_W-1:0]    r_issue;
    logic [POP_W-1:0]    r_recv;
    logic [PEND_W-1:0]   r_pend;

    logic                w_start;
    logic                w_req;
    logic                w_accept;
    logic                w_rx;
    logic                w_last_issue;
    logic                w_finish;
    logic [DATA_W-1:0]   w_diff;
    logic [FIT_W-1:0]    w_mismatch;
    logic [FIT_W-1:0]    w_fit;
    logic [31:0]         w_worst_rd;
    logic                w_unused;

    // Start is only honoured from IDLE; a start while busy is dropped.
    assign w_start  = hps_chipselect && hps_write && (hps_address == 3'd0) &&
                      hps_writedata[0] && (r_state == S_IDLE);
    assign w_accept = w_req && !sdram_waitrequest;
    // Data outside a run (e.g. stragglers from a run killed by reset) is dropped.
    assign w_rx     = sdram_readdatavalid && (r_state != S_IDLE);
    assign w_last_issue = w_accept && ((r_issue + c_POP_ONE) == r_count);
    assign w_finish = (r_state == S_DRAIN) && w_rx && ((r_recv + c_POP_ONE) == r_count);

    // Address depends only on registered state, so it stays stable under stall.
    assign sdram_address      = r_base + (ADDR_W'(r_issue) * c_WORD_BYTES);
    assign sdram_byteenable_n = '0;
    assign sdram_chipselect   = w_req;
    assign sdram_read_n       = !w_req;
    assign hps_waitrequest    = reset;
    assign w_unused           = ^{hps_read, hps_writedata};

    // Fitness = number of bit positions where the word equals the target.
    assign w_diff = sdram_readdata ^ r_target;
    always_comb begin
        w_mismatch = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_mismatch = w_mismatch + FIT_W'(w_diff[i]);
        end
    end
    assign w_fit = c_FIT_MAX - w_mismatch;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start && (r_count != '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_req = (r_issue < r_count) && (r_pend < c_MAX_OUT);
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_finish) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base     <= '0;
            r_count    <= '0;
            r_target   <= '0;
            r_best_fit <= '0;
            r_best_idx <= '0;
            r_sum_fit  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_issue    <= '0;
            r_recv     <= '0;
            r_pend     <= '0;
        end else begin
            if (hps_chipselect && hps_write && !r_busy) begin
                case (hps_address)
                    3'd1:    r_base   <= hps_writedata[ADDR_W-1:0];
                    3'd2:    r_count  <= hps_writedata[POP_W-1:0];
                    3'd3:    r_target <= hps_writedata[DATA_W-1:0];
                    default: ;
                endcase
            end

            if (w_start) begin
                r_best_fit <= '0;
                r_best_idx <= '0;
                r_sum_fit  <= '0;
                r_issue    <= '0;
                r_recv     <= '0;
                r_pend     <= '0;
                // An empty population completes immediately.
                r_done     <= (r_count == '0);
                r_busy     <= (r_count != '0);
            end else begin
                if (w_accept) begin
                    r_issue <= r_issue + c_POP_ONE;
                end

                if (w_accept && !w_rx) begin
                    r_pend <= r_pend + c_PEND_ONE;
                end else if (!w_accept && w_rx) begin
                    r_pend <= r_pend - c_PEND_ONE;
                end

                if (w_rx) begin
                    r_sum_fit <= r_sum_fit + SUM_W'(w_fit);
                    // Strict '>' keeps the lower index on ties.
                    if ((r_recv == '0) || (w_fit > r_best_fit)) begin
                        r_best_fit <= w_fit;
                        r_best_idx <= r_recv;
                    end
                    r_recv <= r_recv + c_POP_ONE;
                end

                if (w_finish) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

`ifdef GAA_FITNESS_WORST_EN
    logic [FIT_W-1:0] r_worst_fit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_worst_fit <= c_FIT_MAX;
        end else if (w_start) begin
            r_worst_fit <= c_FIT_MAX;
        end else if (w_rx && ((r_recv == '0) || (w_fit < r_worst_fit))) begin
            r_worst_fit <= w_fit;
        end
    end

    assign w_worst_rd = 32'(r_worst_fit);
`else
    assign w_worst_rd = '0;
`endif

    // ------------------------------------------------------- register read
    always_comb begin
        hps_readdata = '0;
        case (hps_address)
            3'd0:    hps_readdata = {30'b0, r_done, r_busy};
            3'd1:    hps_readdata = 32'(r_base);
            3'd2:    hps_readdata = 32'(r_count);
            3'd3:    hps_readdata = 32'(r_target);
            3'd4:    hps_readdata = 32'(r_best_fit);
            3'd5:    hps_readdata = 32'(r_best_idx);
            3'd6:    hps_readdata = 32'(r_sum_fit);
            3'd7:    hps_readdata = w_worst_rd;
            default: hps_readdata = '0;
        endcase
    end

endmodule

`default_nettype wire
